// File: rtl/approx_mult_bist.sv
// approx_mult_bist: exhaustive-sweep BIST engine that scores an 8x8 approximate multiplier against exact a*b.
// Optional error-distance statistics (err_sum, max_ed) are built only when BIST_ED_STATS_EN is defined.
module approx_mult_bist #(
  parameter int W = 8,
  parameter int LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_y,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   correct_cnt,
  output logic [31:0]    err_sum,
  output logic [2*W-1:0] max_ed
);
  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
  state_t state, state_nxt;
  logic [2*W-1:0] exp_q [LAT+1];
  logic [LAT:0] vld;
  logic [2*W-1:0] k_nxt, exp_nxt;
  logic go, issue, cmp, hit;
  assign go = start && (state == IDLE || state == DONE);
  assign issue = go || state == SWEEP;
  assign k_nxt = go ? '0 : {mul_a, mul_b} + (2*W)'(1);
  assign exp_nxt = (2*W)'(k_nxt[2*W-1:W]) * (2*W)'(k_nxt[W-1:0]);
  assign cmp = vld[LAT];
  assign hit = mul_y == exp_q[LAT];
  // DRAIN ends one edge after the final compare has shifted out of the valid pipe
  always_comb
    state_nxt = go ? SWEEP :
                (state == SWEEP && &k_nxt) ? DRAIN :
                (state == DRAIN && vld == '0) ? DONE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      correct_cnt <= '0;
      vld <= '0;
    end else begin
      state <= state_nxt;
      busy <= state_nxt == SWEEP || state_nxt == DRAIN;
      done <= state_nxt == DONE;
      if (issue) {mul_a, mul_b} <= k_nxt;
      vld[0] <= issue;
      for (int i = 1; i <= LAT; i++) vld[i] <= vld[i-1];
      correct_cnt <= go ? '0 : (cmp && hit) ? correct_cnt + (2*W+1)'(1) : correct_cnt;
    end
  end
  always_ff @(posedge clk) begin
    exp_q[0] <= exp_nxt;
    for (int i = 1; i <= LAT; i++) exp_q[i] <= exp_q[i-1];
  end
`ifdef BIST_ED_STATS_EN
  logic [2*W:0] diff, ed;
  logic [32:0] acc;
  assign diff = {1'b0, mul_y} - {1'b0, exp_q[LAT]};
  assign ed = diff[2*W] ? -diff : diff;
  assign acc = {1'b0, err_sum} + 33'(ed[2*W-1:0]);
  always_ff @(posedge clk) begin
    if (rst || go) begin
      err_sum <= '0;
      max_ed <= '0;
    end else if (cmp) begin
      err_sum <= acc[32] ? '1 : acc[31:0];
      max_ed <= (ed[2*W-1:0] > max_ed) ? ed[2*W-1:0] : max_ed;
    end
  end
`else
  assign err_sum = '0;
  assign max_ed = '0;
`endif
endmodule

// File: tb/tb_approx_mult_bist.sv
// tb_approx_mult_bist: randomized self-checking bench for approx_mult_bist at W=4 with LAT=0/1/2 instances.
module tb_approx_mult_bist;
  localparam int W = 4;
  localparam int N = 1 << (2*W);
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  int mode = 0;
  int n_chk = 0, n_err = 0;
  logic [2*W-1:0] err_tab [N];
  logic [W-1:0] a0, b0, a1, b1, a2, b2;
  logic [2*W-1:0] y0, y1, y1q, y1qq, y2q, y2qq;
  logic busy0, done0, busy1, done1, busy2, done2;
  logic [2*W:0] cc0, cc1, cc2;
  logic [31:0] es0, es1, es2;
  logic [2*W-1:0] me0, me1, me2;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] stub(input int m, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    return m == 0 ? p : m == 1 ? {p[2*W-1:1], 1'b0} : m == 2 ? '0 : p ^ err_tab[{a, b}];
  endfunction

  assign y0 = stub(mode, a0, b0);
  assign y1 = stub(mode, a1, b1);
  always @(posedge clk) begin
    y1q <= y1;
    y1qq <= y1q;
    y2q <= stub(mode, a2, b2);
    y2qq <= y2q;
  end

  approx_mult_bist #(.W(W), .LAT(0)) u0 (.clk(clk), .rst(rst), .start(start), .mul_a(a0), .mul_b(b0),
    .mul_y(y0), .busy(busy0), .done(done0), .correct_cnt(cc0), .err_sum(es0), .max_ed(me0));
  approx_mult_bist #(.W(W), .LAT(1)) u1 (.clk(clk), .rst(rst), .start(start), .mul_a(a1), .mul_b(b1),
    .mul_y(y1qq), .busy(busy1), .done(done1), .correct_cnt(cc1), .err_sum(es1), .max_ed(me1));
  approx_mult_bist #(.W(W), .LAT(2)) u2 (.clk(clk), .rst(rst), .start(start), .mul_a(a2), .mul_b(b2),
    .mul_y(y2qq), .busy(busy2), .done(done2), .correct_cnt(cc2), .err_sum(es2), .max_ed(me2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sweep(input int m, input int pulse_at);
    int e0, e1, e2, cnt, emax;
    longint sum;
    e0 = -1; e1 = -1; e2 = -1; cnt = 0; sum = 0; emax = 0;
    mode = m;
    for (int a = 0; a < (1 << W); a++)
      for (int b = 0; b < (1 << W); b++) begin
        int p, y, ed;
        p = a * b;
        y = int'(stub(m, W'(a), W'(b)));
        ed = y > p ? y - p : p - y;
        cnt += (ed == 0) ? 1 : 0;
        sum += ed;
        emax = ed > emax ? ed : emax;
      end
`ifndef BIST_ED_STATS_EN
    sum = 0;
    emax = 0;
`endif
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 check("busy_go", busy0, 1'b1);
    for (int t = 1; t <= N + 20 && (e0 < 0 || e1 < 0 || e2 < 0); t++) begin
      @(negedge clk) start = (t == pulse_at);
      @(posedge clk);
      #1;
      if (done0 && e0 < 0) e0 = t;
      if (done1 && e1 < 0) e1 = t;
      if (done2 && e2 < 0) e2 = t;
    end
    start = 1'b0;
    check($sformatf("t_lat0_m%0d", m), 64'(e0), 64'(N + 1));
    check($sformatf("t_lat1_m%0d", m), 64'(e1), 64'(N + 2));
    check($sformatf("t_lat2_m%0d", m), 64'(e2), 64'(N + 3));
    check($sformatf("cnt0_m%0d", m), 64'(cc0), 64'(cnt));
    check($sformatf("cnt2_m%0d", m), 64'(cc2), 64'(cnt));
    check($sformatf("sum0_m%0d", m), 64'(es0), 64'(sum));
    check($sformatf("max0_m%0d", m), 64'(me0), 64'(emax));
    check($sformatf("sum2_m%0d", m), 64'(es2), 64'(sum));
    check($sformatf("hold_m%0d", m), {a0, b0}, 64'(N - 1));
    check($sformatf("busy_done_m%0d", m), busy0, 1'b0);
    if (m == 0) check("lat1_short", 64'(cc1 < (2*W+1)'(N)), 64'(1));
  endtask

  initial begin
    foreach (err_tab[i]) err_tab[i] = ($urandom_range(0, 3) == 0) ? (2*W)'($urandom) : '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_ops", {a0, b0}, 64'(0));
    check("rst_cnt", 64'(cc0), 64'(0));
    check("rst_sum", 64'(es0), 64'(0));
    check("rst_max", 64'(me0), 64'(0));
    @(negedge clk) rst = 1'b0;
    sweep(0, 0);
    sweep(1, 0);
    sweep(2, 0);
    sweep(3, 0);
    sweep(0, 50);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_busy", {busy0, busy2}, 64'(0));
    check("mid_rst_done", {done0, done2}, 64'(0));
    check("mid_rst_ops", {a0, b0, a2, b2}, 64'(0));
    check("mid_rst_cnt", {cc0, cc2}, 64'(0));
    check("mid_rst_ed", {es0, me0}, 64'(0));
    @(negedge clk) rst = 1'b0;
    sweep(3, 0);
    sweep(0, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
